dual_issue_dispatch: RTL

- Producer side of the per-component slot select in the dual-issue decode/execute path.
- Accepts up to two decoded instructions per cycle (slot 1 = older, slot 2 = younger) and resolves intra-pair hazards.
- Steers each instruction to one of two execution lanes and registers the result as the ID/EX lane bundles plus per-lane choose_comp flags.
- Lane 0 executes everything. Lane 1 executes only non-memory, non-control instructions.

---
 rtl/dual_issue_dispatch_pkg.sv | 33 +++
 rtl/dual_issue_dispatch_pair_hazard_check.sv | 35 +++
 rtl/dual_issue_dispatch.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/dual_issue_dispatch_pkg.sv
// Shared widths, state encoding and lane indices for the dual-issue dispatch slice.
// The bundle width is the sum of the decoded fields the bundle carries.
package dual_issue_dispatch_pkg;

  localparam int PC_WIDTH     = 32;
  localparam int IMM_WIDTH    = 16;
  localparam int FUNCT_WIDTH  = 6;
  localparam int JUMP_WIDTH   = 26;
  localparam int OPCODE_WIDTH = 6;
  localparam int DWIDTH       = 32;
  localparam int AWIDTH       = 5;
  localparam int CTRL_WIDTH   = 5;

  localparam int BUNDLE_WIDTH = PC_WIDTH + IMM_WIDTH + FUNCT_WIDTH + JUMP_WIDTH
                              + OPCODE_WIDTH + DWIDTH + AWIDTH + CTRL_WIDTH;

  localparam int LANE0     = 0;
  localparam int LANE1     = 1;
  localparam int NUM_LANES = 2;

  typedef enum logic {
    DISPATCH_PAIR = 1'b0,
    DISPATCH_HOLD = 1'b1
  } dispatch_state_e;

  // True when a register write to dst is observed by a read of addr; $0 never counts.
  function automatic logic dst_hits(input logic             reg_write,
                                    input logic [AWIDTH-1:0] dst,
                                    input logic [AWIDTH-1:0] addr);
    return reg_write && (dst != '0) && (dst == addr);
  endfunction

endpackage

// File: rtl/dual_issue_dispatch_pair_hazard_check.sv
// Combinational intra-pair hazard check: decides whether the younger slot must
// wait a cycle (conflict) or the pair issues with lanes swapped (swap).
module pair_hazard_check
  import dual_issue_dispatch_pkg::*;
(
  input  logic              s1_valid,
  input  logic              s1_l0_only,
  input  logic              s1_reg_write,
  input  logic [AWIDTH-1:0] s1_dst,
  input  logic              s2_valid,
  input  logic              s2_l0_only,
  input  logic              s2_reg_write,
  input  logic [AWIDTH-1:0] s2_dst,
  input  logic [AWIDTH-1:0] s2_addr_rs,
  input  logic [AWIDTH-1:0] s2_addr_rt,
  output logic              conflict,
  output logic              swap
);

  logic both_valid;
  logic raw_hazard;
  logic waw_hazard;
  logic lane0_clash;

  assign both_valid  = s1_valid && s2_valid;
  assign raw_hazard  = dst_hits(s1_reg_write, s1_dst, s2_addr_rs)
                    || dst_hits(s1_reg_write, s1_dst, s2_addr_rt);
  assign waw_hazard  = s2_reg_write && dst_hits(s1_reg_write, s1_dst, s2_dst);
  assign lane0_clash = s1_l0_only && s2_l0_only;

  assign conflict = both_valid && (raw_hazard || waw_hazard || lane0_clash);
  // Only lane 0 can run the younger instruction, so the older one moves to lane 1.
  assign swap     = both_valid && !conflict && s2_l0_only;

endmodule

// File: rtl/dual_issue_dispatch.sv
// Dual-issue dispatch: steers a decoded instruction pair onto two execution lanes,
// splitting hazardous pairs over two cycles via a one-entry hold buffer.
module dual_issue_dispatch
  import dual_issue_dispatch_pkg::*;
#(
  parameter int BUNDLE_W = BUNDLE_WIDTH
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall,
  input  logic                flush,
  input  logic                s1_i_valid,
  input  logic [BUNDLE_W-1:0] s1_i_bundle,
  input  logic                s1_i_l0_only,
  input  logic                s1_i_reg_write,
  input  logic [AWIDTH-1:0]   s1_i_dst,
  input  logic [AWIDTH-1:0]   s1_i_addr_rs,
  input  logic [AWIDTH-1:0]   s1_i_addr_rt,
  input  logic                s2_i_valid,
  input  logic [BUNDLE_W-1:0] s2_i_bundle,
  input  logic                s2_i_l0_only,
  input  logic                s2_i_reg_write,
  input  logic [AWIDTH-1:0]   s2_i_dst,
  input  logic [AWIDTH-1:0]   s2_i_addr_rs,
  input  logic [AWIDTH-1:0]   s2_i_addr_rt,
  output logic                in_o_ready,
  output logic                l0_o_valid,
  output logic [BUNDLE_W-1:0] l0_o_bundle,
  output logic                l0_o_choose_comp,
  output logic                l1_o_valid,
  output logic [BUNDLE_W-1:0] l1_o_bundle,
  output logic                l1_o_choose_comp,
  output logic                l0_o_older
);

  dispatch_state_e     state_reg, state_next;
  logic                hold_valid_reg, hold_valid_next;
  logic [BUNDLE_W-1:0] hold_bundle_reg, hold_bundle_next;
  logic                older_reg, older_next;

  logic                lane_valid_reg  [NUM_LANES];
  logic                lane_valid_next [NUM_LANES];
  logic [BUNDLE_W-1:0] lane_bundle_reg  [NUM_LANES];
  logic [BUNDLE_W-1:0] lane_bundle_next [NUM_LANES];
  logic                lane_choose_reg  [NUM_LANES];
  logic                lane_choose_next [NUM_LANES];

  logic conflict;
  logic swap;

  // Slot 1 sources cannot hazard against the younger slot; they only pass through decode.
  logic unused_s1_srcs;
  assign unused_s1_srcs = ^{s1_i_addr_rs, s1_i_addr_rt};

  pair_hazard_check u_hazard (
    .s1_valid     (s1_i_valid),
    .s1_l0_only   (s1_i_l0_only),
    .s1_reg_write (s1_i_reg_write),
    .s1_dst       (s1_i_dst),
    .s2_valid     (s2_i_valid),
    .s2_l0_only   (s2_i_l0_only),
    .s2_reg_write (s2_i_reg_write),
    .s2_dst       (s2_i_dst),
    .s2_addr_rs   (s2_i_addr_rs),
    .s2_addr_rt   (s2_i_addr_rt),
    .conflict     (conflict),
    .swap         (swap)
  );

  assign in_o_ready = (state_reg == DISPATCH_PAIR) && !stall && !flush;

  always_comb begin
    state_next       = state_reg;
    hold_valid_next  = hold_valid_reg;
    hold_bundle_next = hold_bundle_reg;
    older_next       = older_reg;
    lane_valid_next  = lane_valid_reg;
    lane_bundle_next = lane_bundle_reg;
    lane_choose_next = lane_choose_reg;

    if (flush) begin
      lane_valid_next[LANE0] = 1'b0;
      lane_valid_next[LANE1] = 1'b0;
      hold_valid_next        = 1'b0;
      state_next             = DISPATCH_PAIR;
    end else if (!stall) begin
      lane_valid_next[LANE1] = 1'b0;
      if (state_reg == DISPATCH_HOLD) begin
        lane_valid_next[LANE0]  = hold_valid_reg;
        lane_bundle_next[LANE0] = hold_bundle_reg;
        lane_choose_next[LANE0] = 1'b0;
        older_next              = 1'b1;
        hold_valid_next         = 1'b0;
        state_next              = DISPATCH_PAIR;
      end else if (conflict) begin
        lane_valid_next[LANE0]  = 1'b1;
        lane_bundle_next[LANE0] = s1_i_bundle;
        lane_choose_next[LANE0] = 1'b1;
        older_next              = 1'b1;
        hold_valid_next         = 1'b1;
        hold_bundle_next        = s2_i_bundle;
        state_next              = DISPATCH_HOLD;
      end else if (swap) begin
        lane_valid_next[LANE0]  = 1'b1;
        lane_bundle_next[LANE0] = s2_i_bundle;
        lane_choose_next[LANE0] = 1'b0;
        lane_valid_next[LANE1]  = 1'b1;
        lane_bundle_next[LANE1] = s1_i_bundle;
        lane_choose_next[LANE1] = 1'b1;
        older_next              = 1'b0;
      end else if (s1_i_valid) begin
        lane_valid_next[LANE0]  = 1'b1;
        lane_bundle_next[LANE0] = s1_i_bundle;
        lane_choose_next[LANE0] = 1'b1;
        older_next              = 1'b1;
        if (s2_i_valid) begin
          lane_valid_next[LANE1]  = 1'b1;
          lane_bundle_next[LANE1] = s2_i_bundle;
          lane_choose_next[LANE1] = 1'b0;
        end
      end else if (s2_i_valid) begin
        lane_valid_next[LANE0]  = 1'b1;
        lane_bundle_next[LANE0] = s2_i_bundle;
        lane_choose_next[LANE0] = 1'b0;
        older_next              = 1'b1;
      end else begin
        lane_valid_next[LANE0] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= DISPATCH_PAIR;
      hold_valid_reg  <= 1'b0;
      hold_bundle_reg <= '0;
      older_reg       <= 1'b0;
    end else begin
      state_reg       <= state_next;
      hold_valid_reg  <= hold_valid_next;
      hold_bundle_reg <= hold_bundle_next;
      older_reg       <= older_next;
    end
  end

  for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
    always_ff @(posedge clk) begin
      if (rst) begin
        lane_valid_reg[gi]  <= 1'b0;
        lane_bundle_reg[gi] <= '0;
        lane_choose_reg[gi] <= 1'b0;
      end else begin
        lane_valid_reg[gi]  <= lane_valid_next[gi];
        lane_bundle_reg[gi] <= lane_bundle_next[gi];
        lane_choose_reg[gi] <= lane_choose_next[gi];
      end
    end
  end

  assign l0_o_valid       = lane_valid_reg[LANE0];
  assign l0_o_bundle      = lane_bundle_reg[LANE0];
  assign l0_o_choose_comp = lane_choose_reg[LANE0];
  assign l1_o_valid       = lane_valid_reg[LANE1];
  assign l1_o_bundle      = lane_bundle_reg[LANE1];
  assign l1_o_choose_comp = lane_choose_reg[LANE1];
  assign l0_o_older       = older_reg;

endmodule
